// File: rtl/cam_i2c_target.sv
// I2C/SCCB target: START, device byte, sub-address, one data byte written or read, STOP.
// Fronts a register file through a single-cycle port; SDA is open-drain (0 or z only).
module cam_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h60,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       addr_match,
    output logic       rd_nack
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DEV_ADDR  = 4'd1;
    localparam logic [3:0] S_ACK_DEV   = 4'd2;
    localparam logic [3:0] S_SUB_ADDR  = 4'd3;
    localparam logic [3:0] S_ACK_SUB   = 4'd4;
    localparam logic [3:0] S_WR_DATA   = 4'd5;
    localparam logic [3:0] S_ACK_WR    = 4'd6;
    localparam logic [3:0] S_RD_DATA   = 4'd7;
    localparam logic [3:0] S_MSTR_ACK  = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_q, sda_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] state;
    logic [2:0] bitcnt;
    logic       full;
    logic [7:0] shreg;
    logic       rw_bit;
    logic       sda_low;
    logic [1:0] load_cnt;

    // NOTE: rst gates the driver combinationally so the bus is released in the reset clk itself.
    assign SDA = (sda_low && !rst) ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    // Idle bus level is high, so the synchronizers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bitcnt     <= 3'd7;
            full       <= 1'b0;
            shreg      <= 8'h00;
            rw_bit     <= 1'b0;
            sda_low    <= 1'b0;
            load_cnt   <= 2'd0;
            reg_addr   <= 8'h00;
            reg_wdata  <= 8'h00;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
            addr_match <= 1'b0;
            rd_nack    <= 1'b0;
        end else begin
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            addr_match <= 1'b0;
            if (start_det) begin
                state    <= S_DEV_ADDR;
                bitcnt   <= 3'd7;
                full     <= 1'b0;
                sda_low  <= 1'b0;
                load_cnt <= 2'd0;
                busy     <= 1'b1;
                rd_nack  <= 1'b0;
            end else if (stop_det) begin
                state    <= S_IDLE;
                bitcnt   <= 3'd7;
                full     <= 1'b0;
                sda_low  <= 1'b0;
                load_cnt <= 2'd0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_DEV_ADDR, S_SUB_ADDR, S_WR_DATA: begin
                        // Bits are counted on rising edges; the byte completes on the following fall.
                        if (scl_rise) begin
                            shreg <= {shreg[6:0], sda_s};
                            if (state == S_SUB_ADDR)
                                reg_addr <= {reg_addr[6:0], sda_s};
                            if (bitcnt == 3'd0)
                                full <= 1'b1;
                            else
                                bitcnt <= bitcnt - 3'd1;
                        end else if (scl_fall && full) begin
                            full   <= 1'b0;
                            bitcnt <= 3'd7;
                            if (state == S_DEV_ADDR) begin
                                if (shreg[7:1] == DEV_ADDR) begin
                                    sda_low    <= 1'b1;
                                    addr_match <= 1'b1;
                                    rw_bit     <= shreg[0];
                                    state      <= S_ACK_DEV;
                                end else begin
                                    state <= S_WAIT_STOP;
                                end
                            end else if (state == S_SUB_ADDR) begin
                                sda_low <= 1'b1;
                                state   <= S_ACK_SUB;
                            end else begin
                                sda_low   <= 1'b1;
                                reg_we    <= 1'b1;
                                reg_wdata <= shreg;
                                state     <= S_ACK_WR;
                            end
                        end
                    end
                    S_ACK_DEV: if (scl_fall) begin
                        sda_low <= 1'b0;
                        state   <= S_SUB_ADDR;
                    end
                    S_ACK_SUB: if (scl_fall) begin
                        sda_low <= 1'b0;
                        bitcnt  <= 3'd7;
                        if (rw_bit) begin
                            reg_re   <= 1'b1;
                            load_cnt <= 2'd2;
                            state    <= S_RD_DATA;
                        end else begin
                            state <= S_WR_DATA;
                        end
                    end
                    S_ACK_WR: if (scl_fall) begin
                        sda_low <= 1'b0;
                        state   <= S_WAIT_STOP;
                    end
                    S_RD_DATA: begin
                        // Read data is valid the clk after reg_re, so capture two clks after the request.
                        if (load_cnt != 2'd0) begin
                            load_cnt <= load_cnt - 2'd1;
                            if (load_cnt == 2'd1) begin
                                shreg   <= reg_rdata;
                                sda_low <= ~reg_rdata[7];
                            end
                        end else if (scl_fall) begin
                            if (bitcnt == 3'd0) begin
                                sda_low <= 1'b0;
                                bitcnt  <= 3'd7;
                                state   <= S_MSTR_ACK;
                            end else begin
                                bitcnt  <= bitcnt - 3'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_low <= ~shreg[6];
                            end
                        end
                    end
                    S_MSTR_ACK: if (scl_rise) begin
                        if (sda_s)
                            rd_nack <= 1'b1;
                        state <= S_WAIT_STOP;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
